// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seg_scan_driver : multiplexed 7-segment scanner, frame-synchronous data latch,
//                   per-digit dp / blink / leading-zero blanking, 16-level PWM.
// Revision 1.0
// ============================================================================
module seg_scan_driver #(
   parameter int DIGITS         = 8,
   parameter int SCAN_DIV       = 5000,
   parameter int BLINK_DIV      = 5000000,
   parameter int COM_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [4*DIGITS-1:0]   load_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  load_valid_i,
   input  logic [DIGITS-1:0]     blink_mask_i,
   input  logic                  blank_lz_i,
   input  logic [3:0]            brightness_i,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     segcom_o,
   output logic                  frame_done_o
);

   localparam int TW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int PW = TW + 5;

   localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7f;
   localparam logic [6:0]        SEG_OFF = 7'h7f ^ SEG_INV;
   localparam logic [DIGITS-1:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [TW-1:0]       tick_q, tick_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                blink_ph_q, blink_ph_d;
   logic [4*DIGITS-1:0] pend_data_q, pend_data_d, shadow_data_q, shadow_data_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, shadow_dp_q, shadow_dp_d;
   logic                pend_flag_q, pend_flag_d;
   logic                wrap_q;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   segcom_q, segcom_d;
   logic                frame_done_q;

   logic                tick_end, wrap, blink_end;
   logic [PW-1:0]       on_len;
   logic [DIGITS-1:0]   upper_zero;
   logic [3:0]          cur_nib;
   logic                cur_dp, cur_blink, cur_lz, blank;
   logic [6:0]          pat_al;
   logic [DIGITS-1:0]   com_ah;

   always_comb begin
      tick_end    = (tick_q == TW'(SCAN_DIV - 1));
      wrap        = tick_end && (idx_q == IW'(DIGITS - 1));
      tick_d      = tick_end ? '0 : tick_q + TW'(1);
      idx_d       = idx_q;
      if (tick_end) idx_d = wrap ? '0 : idx_q + IW'(1);
      blink_end   = (blink_cnt_q == BW'(BLINK_DIV - 1));
      blink_cnt_d = blink_end ? '0 : blink_cnt_q + BW'(1);
      blink_ph_d  = blink_ph_q ^ blink_end;
   end

   // A load on the wrap cycle itself bypasses pending so it is not delayed a whole frame.
   always_comb begin
      pend_data_d   = pend_data_q;
      pend_dp_d     = pend_dp_q;
      pend_flag_d   = pend_flag_q | load_valid_i;
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      if (load_valid_i) begin
         pend_data_d = load_i;
         pend_dp_d   = dp_i;
      end
      if (wrap) begin
         pend_flag_d = 1'b0;
         if (load_valid_i) begin
            shadow_data_d = load_i;
            shadow_dp_d   = dp_i;
         end else if (pend_flag_q) begin
            shadow_data_d = pend_data_q;
            shadow_dp_d   = pend_dp_q;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
         if (gi == DIGITS - 1) begin : g_top
            assign upper_zero[gi] = (shadow_data_q[4*gi +: 4] == 4'h0);
         end else begin : g_chain
            assign upper_zero[gi] = upper_zero[gi+1] && (shadow_data_q[4*gi +: 4] == 4'h0);
         end
      end
   endgenerate

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib   = shadow_data_q[4*i +: 4];
            cur_dp    = shadow_dp_q[i];
            cur_blink = blink_mask_i[i];
            cur_lz    = (i > 0) && upper_zero[i];
         end
      end
      blank = (cur_blink && blink_ph_q) || (blank_lz_i && cur_lz);
   end

   always_comb begin
      case (cur_nib)
         4'h0: pat_al = 7'b1000000;
         4'h1: pat_al = 7'b1111001;
         4'h2: pat_al = 7'b0100100;
         4'h3: pat_al = 7'b0110000;
         4'h4: pat_al = 7'b0011001;
         4'h5: pat_al = 7'b0010010;
         4'h6: pat_al = 7'b0000010;
         4'h7: pat_al = 7'b1111000;
         4'h8: pat_al = 7'b0000000;
         4'h9: pat_al = 7'b0010000;
         4'hA: pat_al = 7'b0001000;
         4'hB: pat_al = 7'b0000011;
         4'hC: pat_al = 7'b1000110;
         4'hD: pat_al = 7'b0100001;
         4'hE: pat_al = 7'b0000110;
         default: pat_al = 7'b0001110;
      endcase
   end

   always_comb begin
      on_len   = ((PW'(brightness_i) + PW'(1)) * PW'(SCAN_DIV)) >> 4;
      com_ah   = '0;
      if ({{(PW-TW){1'b0}}, tick_q} < on_len) com_ah = DIGITS'(1) << idx_q;
      segcom_d = (COM_ACTIVE_LOW != 0) ? ~com_ah : com_ah;
      seg_d    = blank ? SEG_OFF : (pat_al ^ SEG_INV);
      dp_d     = ((blank || !cur_dp) ? 1'b1 : 1'b0) ^ SEG_INV[0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_q        <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_ph_q    <= 1'b0;
         pend_data_q   <= '0;
         pend_dp_q     <= '0;
         pend_flag_q   <= 1'b0;
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         wrap_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         seg_q         <= SEG_OFF;
         dp_q          <= SEG_OFF[0];
         segcom_q      <= COM_OFF;
      end else begin
         tick_q        <= tick_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_ph_q    <= blink_ph_d;
         pend_data_q   <= pend_data_d;
         pend_dp_q     <= pend_dp_d;
         pend_flag_q   <= pend_flag_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         wrap_q        <= wrap;
         frame_done_q  <= wrap_q;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         segcom_q      <= segcom_d;
      end
   end

   assign seg_o        = seg_q;
   assign dp_o         = dp_q;
   assign segcom_o     = segcom_q;
   assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_driver : checks seg_scan_driver (4 digits, 16-cycle slots) against
//                      a frame/slot arithmetic reference model.
// Revision 1.0
// ============================================================================
module tb_seg_scan_driver;

   localparam int D  = 4;
   localparam int S  = 16;
   localparam int BD = 64;
   localparam int FR = D * S;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ld;
   logic [3:0]  dpin;
   logic        lv;
   logic [3:0]  bmask;
   logic        blz;
   logic [3:0]  br;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  segcom;
   logic        fd;

   int total = 0;
   int bad   = 0;

   // Reference state: n = clock edges since reset release, plus displayed/pending data.
   int          n;
   logic [15:0] m_sh, m_pv;
   logic [3:0]  m_shdp, m_pdp;
   bit          m_pend;

   string lit_tab [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   seg_scan_driver #(
      .DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(BD), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .load_i(ld), .dp_i(dpin), .load_valid_i(lv),
      .blink_mask_i(bmask), .blank_lz_i(blz), .brightness_i(br),
      .seg_o(seg), .dp_o(dp), .segcom_o(segcom), .frame_done_o(fd)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] r;
      string      s;
      int         b;
      r = 7'h7f;
      s = lit_tab[v];
      for (int k = 0; k < s.len(); k++) begin
         b = int'(s[k]) - 97;
         r[b] = 1'b0;
      end
      return r;
   endfunction

   task automatic model_reset();
      n = 0; m_sh = '0; m_pv = '0; m_shdp = '0; m_pdp = '0; m_pend = 1'b0;
   endtask

   task automatic chk_rst(input string tag);
      total++;
      assert (segcom === 4'hF) else begin bad++; $error("FAIL %s segcom observed=%b expected=1111", tag, segcom); end
      total++;
      assert (seg === 7'h7f) else begin bad++; $error("FAIL %s seg observed=%b expected=1111111", tag, seg); end
      total++;
      assert (dp === 1'b1) else begin bad++; $error("FAIL %s dp observed=%b expected=1", tag, dp); end
      total++;
      assert (fd === 1'b0) else begin bad++; $error("FAIL %s frame_done observed=%b expected=0", tag, fd); end
   endtask

   task automatic cyc();
      int          p, idx, tick, on;
      bit          ph, blank;
      logic [15:0] upper;
      logic [3:0]  e_com;
      logic [6:0]  e_seg;
      logic        e_dp, e_fd;
      @(posedge clk);
      p     = n % FR;
      idx   = p / S;
      tick  = n % S;
      ph    = ((n / BD) % 2) == 1;
      on    = ((int'(br) + 1) * S) / 16;
      upper = m_sh >> (4 * idx);
      blank = (bmask[idx] && ph) || (blz && idx > 0 && upper == 16'h0);
      e_com = (tick < on) ? (4'hF ^ (4'b0001 << idx)) : 4'hF;
      e_seg = blank ? 7'h7f : seg_of(upper[3:0]);
      e_dp  = blank ? 1'b1 : ~m_shdp[idx];
      e_fd  = (n >= FR) && (p == 0);
      #1;
      total++;
      assert (segcom === e_com) else begin bad++; $error("FAIL segcom n=%0d observed=%b expected=%b", n, segcom, e_com); end
      total++;
      assert (seg === e_seg) else begin bad++; $error("FAIL seg n=%0d observed=%b expected=%b", n, seg, e_seg); end
      total++;
      assert (dp === e_dp) else begin bad++; $error("FAIL dp n=%0d observed=%b expected=%b", n, dp, e_dp); end
      total++;
      assert (fd === e_fd) else begin bad++; $error("FAIL frame_done n=%0d observed=%b expected=%b", n, fd, e_fd); end
      if (p == FR - 1) begin
         if (lv) begin
            m_sh = ld; m_shdp = dpin;
         end else if (m_pend) begin
            m_sh = m_pv; m_shdp = m_pdp;
         end
         m_pend = 1'b0;
      end else if (lv) begin
         m_pend = 1'b1; m_pv = ld; m_pdp = dpin;
      end
      n++;
   endtask

   task automatic run_to(input int phase);
      for (int k = 0; k < FR && (n % FR) != phase; k++) cyc();
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      ld = v; dpin = d; lv = 1'b1;
      cyc();
      lv = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ld = '0; dpin = '0; lv = 1'b0; bmask = '0; blz = 1'b0; br = 4'd15;
      model_reset();
      repeat (3) @(posedge clk);
      #1 chk_rst("reset");
      @(negedge clk) rst_n = 1'b1;

      // Scan with 0x1234 loaded on the first wrap cycle
      run_to(FR - 1);
      pulse_load(16'h1234, 4'h0);
      repeat (2 * FR) cyc();

      // Mid-frame load must not tear the current frame
      run_to(20);
      pulse_load(16'hAAAA, 4'h0);
      run_to(0);
      repeat (FR) cyc();

      // Load on the wrap cycle, then a double load overwriting pending
      run_to(FR - 1);
      pulse_load(16'($urandom), 4'($urandom));
      repeat (FR) cyc();
      run_to(10);
      pulse_load(16'($urandom), 4'h0);
      repeat (5) cyc();
      pulse_load(16'($urandom), 4'($urandom));
      repeat (FR) cyc();

      // Leading-zero blanking
      blz = 1'b1;
      pulse_load(16'h0050, 4'h0);
      repeat (2 * FR) cyc();
      pulse_load(16'h0000, 4'h0);
      repeat (2 * FR) cyc();
      blz = 1'b0;

      // Blink and decimal point
      bmask = 4'b0001;
      pulse_load(16'($urandom), 4'b0100);
      repeat (4 * FR) cyc();
      bmask = 4'b0000;

      // Brightness extremes and midpoint
      br = 4'd0;
      repeat (FR) cyc();
      br = 4'd7;
      repeat (FR) cyc();
      br = 4'd15;

      // Randomised live inputs and sporadic loads
      for (int k = 0; k < 800; k++) begin
         br    = 4'($urandom);
         bmask = 4'($urandom);
         blz   = 1'($urandom);
         ld    = 16'($urandom);
         dpin  = 4'($urandom);
         lv    = ($urandom_range(0, 19) == 0);
         cyc();
      end
      lv = 1'b0; br = 4'd15; bmask = '0; blz = 1'b0;

      // Asynchronous reset between edges discards pending data
      run_to(30);
      pulse_load(16'hBEEF, 4'hF);
      #3 rst_n = 1'b0;
      #1 chk_rst("async_reset");
      @(posedge clk);
      #1 chk_rst("held_reset");
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      repeat (2 * FR) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
